voice_alloc: RTL
================

# voice_alloc

Polyphonic voice allocator between the MIDI event parser and `synth2`. Maps channel/note events onto voice-slot addresses (the `addr` input of `synth2`), retriggers held notes, and steals a slot round-robin when all slots are busy. Frees a slot when `synth2` reports that the voice's ADSR has reached BLANK (`data`/`data_valid`). Emits single-cycle event pulses with stable note/velocity/channel/addr fields.

## Interface
- `VOICES`, default 64: number of managed slots, 2..256; slots 0..VOICES-1.
- `ADDR_W`, default 8: slot address width; must satisfy 2^ADDR_W ≥ VOICES.
- `clk96`  in  1  system clock (96 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `ev_valid`  in  1  parsed MIDI event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_type`  in  2  0 = note-on, 1 = note-off, 2 = poly key pressure, 3 = pitch wheel.
- `ev_channel`  in  4  MIDI channel.
- `ev_data1`  in  7  note number (pitch wheel: MSB data byte).
- `ev_data2`  in  7  velocity / pressure.
- `voice_done_valid`  in  1  from `synth2.data_valid`.
- `voice_done_addr`  in  ADDR_W  from `synth2.data`.
- `note_pressed`, `note_released`, `note_keypress`, `pitch_wheel`  out  1 each  one-cycle pulses to `synth2`.
- `note`  out  7; `velocity`  out  7; `channel`  out  4; `addr`  out  ADDR_W: event fields, held until the next issue.
- `ev_dropped`  out  1  one-cycle pulse when an event produces no output.
- `active_count`  out  ADDR_W+1  number of entries with `active` = 1.

## Operation
- Per-slot register entry: `active`, `held`, `ch[3:0]`, `nt[6:0]`. Steal pointer `steal_ptr` (ADDR_W bits, wraps at VOICES-1 → 0).
- FSM states: IDLE, SCAN, ISSUE.
- IDLE: `ev_ready` = 1. When `ev_valid` = 1, latch event, drop `ev_ready`. Note-on with `ev_data2` = 0 is converted to note-off. Pitch wheel goes to ISSUE; every other type goes to SCAN with index 0.
- SCAN: one entry per cycle, index 0..VOICES-1. Records the first entry with match = `active` & `held` & `ch`==channel & `nt`==note, and the first entry with `active` = 0. After index VOICES-1, go to ISSUE.
- ISSUE, note-on target priority: match → first free → `steal_ptr`. A steal advances `steal_ptr` by 1. Writes target entry: `active` = 1, `held` = 1, `ch`, `nt`. Pulses `note_pressed`.
- ISSUE, note-off: if a match was found and is still `active`, clear its `held` and pulse `note_released`. Otherwise pulse `ev_dropped`.
- ISSUE, key pressure: if a match was found and is still `active`, pulse `note_keypress` (entry unchanged). Otherwise pulse `ev_dropped`.
- ISSUE, pitch wheel: pulse `pitch_wheel` with `note` = `ev_data1` and `channel`. `addr` is unchanged.
- After ISSUE, return to IDLE.
- Free: `voice_done_valid` clears `active` and `held` of `voice_done_addr` on any cycle. Addresses ≥ VOICES are ignored. If ISSUE writes the same entry in the same cycle, the ISSUE write wins.
- A free arriving mid-scan never invalidates a chosen free slot. A matched slot freed before ISSUE is handled by the ISSUE re-check above.
- `active_count` tracks set/clear of `active`. It is unchanged on retrigger, steal, or a same-cycle issue/free collision.

## Timing
- Reset values: `ev_ready` = 0 during reset, 1 on the first cycle after reset. All pulses 0. `note`, `velocity`, `channel`, `addr`, `active_count`, `steal_ptr` = 0. All entries cleared. State = IDLE.
- Accept cycle C (`ev_valid` & `ev_ready`). Scanned types: output pulse at C+VOICES+1. Pitch wheel: output pulse at C+1.
- `ev_ready` is 0 from C+1 through the ISSUE cycle, and 1 in the cycle after ISSUE. Maximum throughput is one scanned event per VOICES+2 cycles.
- All outputs are registered. Field outputs change only in the cycle their pulse is asserted.
- Asserting `rst` mid-scan aborts the event immediately: no pulse, table cleared.

## Test plan
- Reset, then note-on ch0 note 60 vel 100 → `note_pressed` at C+65 (VOICES = 64), `addr` 0, `active_count` 1. A second note-on ch0 note 64 → `addr` 1.
- Note-on ch0/60 twice → second pulse has `addr` 0 (retrigger), `active_count` stays 1. Note-off ch0/60 → `note_released` with `addr` 0. A repeat note-off ch0/60 → `ev_dropped`.
- Fill 64 slots with distinct notes, then note-on ch1/10 → `addr` 0 (steal), `steal_ptr` = 1. Next overflow note-on → `addr` 1.
- Allocate slots 0–2, pulse `voice_done_valid` with `addr` 1, then note-on → `addr` 1, `active_count` returns to 3. Separately, a free of address 70 leaves the table unchanged.
- Pitch wheel ch9, `ev_data1` = 0x40 → `pitch_wheel` at C+1 with `note` 0x40, `channel` 9, `addr` unchanged. Note-on with vel 0 for a held note → `note_released`.
- Assert `rst` mid-scan → no output pulse, `active_count` 0, `ev_ready` 1 on the cycle after release.

Source files
------------

// File: rtl/voice_alloc_if.sv
// ---------------------------------------------------------------------------
// voice_alloc_if
// Bundles the voice allocator's event input, voice-done return path, issued
// event outputs and debug observation signals.
//
//   ev_valid / ev_ready        parsed MIDI event handshake
//   ev_type, ev_channel,       event payload (type 0 on, 1 off, 2 key
//   ev_data1, ev_data2         pressure, 3 pitch wheel)
//   voice_done_valid/_addr     slot-free reports from synth2
//   note_pressed, note_released,
//   note_keypress, pitch_wheel one-cycle pulses towards synth2
//   note, velocity, channel,
//   addr                       event fields, stable between issues
//   ev_dropped                 one-cycle pulse: event produced no output
//   active_count               number of active slots
//   dbg_state, dbg_steal_ptr   FSM state and steal pointer, for observation
//
// master = event source / synth side (testbench), slave = allocator.
// ---------------------------------------------------------------------------
interface voice_alloc_if #(
  parameter int ADDR_W = 8
);
  logic              ev_valid;
  logic              ev_ready;
  logic [1:0]        ev_type;
  logic [3:0]        ev_channel;
  logic [6:0]        ev_data1;
  logic [6:0]        ev_data2;
  logic              voice_done_valid;
  logic [ADDR_W-1:0] voice_done_addr;
  logic              note_pressed;
  logic              note_released;
  logic              note_keypress;
  logic              pitch_wheel;
  logic [6:0]        note;
  logic [6:0]        velocity;
  logic [3:0]        channel;
  logic [ADDR_W-1:0] addr;
  logic              ev_dropped;
  logic [ADDR_W:0]   active_count;
  logic [1:0]        dbg_state;
  logic [ADDR_W-1:0] dbg_steal_ptr;

  modport master (
    output ev_valid, ev_type, ev_channel, ev_data1, ev_data2,
    output voice_done_valid, voice_done_addr,
    input  ev_ready, note_pressed, note_released, note_keypress, pitch_wheel,
    input  note, velocity, channel, addr, ev_dropped, active_count,
    input  dbg_state, dbg_steal_ptr
  );

  modport slave (
    input  ev_valid, ev_type, ev_channel, ev_data1, ev_data2,
    input  voice_done_valid, voice_done_addr,
    output ev_ready, note_pressed, note_released, note_keypress, pitch_wheel,
    output note, velocity, channel, addr, ev_dropped, active_count,
    output dbg_state, dbg_steal_ptr
  );
endinterface

// File: rtl/voice_alloc.sv
// ---------------------------------------------------------------------------
// voice_alloc
// Polyphonic voice allocator between the MIDI event parser and synth2.
// Maps channel/note events to voice slots, retriggers held notes, steals a
// slot round-robin when every slot is busy, and frees slots when synth2
// reports a voice finished.
//
// Ports:
//   clk96  system clock
//   rst    asynchronous, active-high reset
//   bus    voice_alloc_if.slave (event in, voice-done in, issued events out)
//
// Handshake: an event is accepted on a clock edge where ev_valid and ev_ready
// are both 1. ev_ready is only high in IDLE and drops the cycle after accept;
// it returns the cycle after the issue pulse. ev_valid may change freely while
// ev_ready is low.
//
// Timing: a scanned event is accepted at C, entries 0..VOICES-1 are examined
// in cycles C+1..C+VOICES, and the decision is registered at the end of the
// last scan cycle so the output pulse is visible in the ISSUE cycle,
// C+VOICES+1. Pitch wheel skips the scan; its pulse is registered on the
// accept edge and is visible at C+1.
// ---------------------------------------------------------------------------
module voice_alloc #(
  parameter int VOICES = 64,
  parameter int ADDR_W = 8
) (
  input logic          clk96,
  input logic          rst,
  voice_alloc_if.slave bus
);

  localparam int                IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(VOICES - 1);
  localparam logic [ADDR_W:0]   NUM_V = (ADDR_W + 1)'(VOICES);

  localparam logic [1:0] EV_ON  = 2'd0;
  localparam logic [1:0] EV_OFF = 2'd1;
  localparam logic [1:0] EV_KP  = 2'd2;
  localparam logic [1:0] EV_PW  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched event
  logic [1:0]        r_ev_type;
  logic [3:0]        r_ev_ch;
  logic [6:0]        r_ev_note;
  logic [6:0]        r_ev_vel;

  // Scan bookkeeping
  logic [ADDR_W-1:0] r_idx;
  logic              r_have_match;
  logic              r_have_free;
  logic [IDX_W-1:0]  r_match_idx;
  logic [IDX_W-1:0]  r_free_idx;
  logic [ADDR_W-1:0] r_steal;

  // Slot table
  logic              r_active [VOICES];
  logic              r_held   [VOICES];
  logic [3:0]        r_ch     [VOICES];
  logic [6:0]        r_nt     [VOICES];

  logic [ADDR_W:0]   r_count;
  logic              r_ready;

  // Registered outputs
  logic              r_pressed;
  logic              r_released;
  logic              r_keypress;
  logic              r_pitch;
  logic              r_dropped;
  logic [6:0]        r_note;
  logic [6:0]        r_vel;
  logic [3:0]        r_chan;
  logic [ADDR_W-1:0] r_addr;

  // Combinational decision signals
  logic              w_accept;
  logic              w_scan_last;
  logic [IDX_W-1:0]  w_cur;
  logic              w_cur_match;
  logic              w_cur_free;
  logic              w_fin_has_match;
  logic              w_fin_has_free;
  logic [IDX_W-1:0]  w_fin_match;
  logic [IDX_W-1:0]  w_fin_free;
  logic              w_free_hit;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_match_live;

  logic              w_wr_on;
  logic              w_wr_off;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_steal_adv;
  logic              w_p_pressed;
  logic              w_p_released;
  logic              w_p_keypress;
  logic              w_p_pitch;
  logic              w_p_dropped;
  logic [6:0]        w_note_n;
  logic [6:0]        w_vel_n;
  logic [3:0]        w_chan_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic              w_set;
  logic              w_clr;

  assign w_accept    = bus.ev_valid & r_ready;
  assign w_scan_last = (r_state == ST_SCAN) && (r_idx == LAST);
  assign w_cur       = r_idx[IDX_W-1:0];

  assign w_cur_match = r_active[w_cur] & r_held[w_cur] &
                       (r_ch[w_cur] == r_ev_ch) & (r_nt[w_cur] == r_ev_note);
  assign w_cur_free  = ~r_active[w_cur];

  // Fold the entry being scanned this cycle into the recorded results so the
  // final scan cycle can also make the issue decision.
  assign w_fin_has_match = r_have_match | w_cur_match;
  assign w_fin_match     = r_have_match ? r_match_idx : w_cur;
  assign w_fin_has_free  = r_have_free | w_cur_free;
  assign w_fin_free      = r_have_free ? r_free_idx : w_cur;

  // Frees of addresses outside the managed range are ignored.
  assign w_free_hit = bus.voice_done_valid & ({1'b0, bus.voice_done_addr} < NUM_V);
  assign w_free_idx = bus.voice_done_addr[IDX_W-1:0];

  // A match only counts if the slot has not been freed since it was scanned,
  // including by a free arriving in the decision cycle itself.
  assign w_match_live = w_fin_has_match & r_active[w_fin_match] &
                        ~(w_free_hit & (w_free_idx == w_fin_match));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (bus.ev_type == EV_PW) ? ST_ISSUE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_scan_last) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and table actions (registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    w_wr_on      = 1'b0;
    w_wr_off     = 1'b0;
    w_wr_idx     = '0;
    w_steal_adv  = 1'b0;
    w_p_pressed  = 1'b0;
    w_p_released = 1'b0;
    w_p_keypress = 1'b0;
    w_p_pitch    = 1'b0;
    w_p_dropped  = 1'b0;
    w_note_n     = r_note;
    w_vel_n      = r_vel;
    w_chan_n     = r_chan;
    w_addr_n     = r_addr;

    if ((r_state == ST_IDLE) && w_accept && (bus.ev_type == EV_PW)) begin
      // Pitch wheel is not tied to a slot: addr keeps its last value.
      w_p_pitch = 1'b1;
      w_note_n  = bus.ev_data1;
      w_vel_n   = bus.ev_data2;
      w_chan_n  = bus.ev_channel;
    end else if (w_scan_last) begin
      case (r_ev_type)
        EV_ON: begin
          w_wr_on = 1'b1;
          if (w_match_live) begin
            w_wr_idx = w_fin_match;
          end else if (w_fin_has_free) begin
            w_wr_idx = w_fin_free;
          end else begin
            w_wr_idx    = r_steal[IDX_W-1:0];
            w_steal_adv = 1'b1;
          end
          w_p_pressed = 1'b1;
          w_note_n    = r_ev_note;
          w_vel_n     = r_ev_vel;
          w_chan_n    = r_ev_ch;
          w_addr_n    = ADDR_W'(w_wr_idx);
        end
        EV_OFF: begin
          if (w_match_live) begin
            w_wr_off     = 1'b1;
            w_wr_idx     = w_fin_match;
            w_p_released = 1'b1;
            w_note_n     = r_ev_note;
            w_vel_n      = r_ev_vel;
            w_chan_n     = r_ev_ch;
            w_addr_n     = ADDR_W'(w_fin_match);
          end else begin
            w_p_dropped = 1'b1;
          end
        end
        EV_KP: begin
          if (w_match_live) begin
            w_p_keypress = 1'b1;
            w_note_n     = r_ev_note;
            w_vel_n      = r_ev_vel;
            w_chan_n     = r_ev_ch;
            w_addr_n     = ADDR_W'(w_fin_match);
          end else begin
            w_p_dropped = 1'b1;
          end
        end
        default: w_p_dropped = 1'b1;
      endcase
    end
  end

  // active_count moves only on real transitions of an entry's active bit.
  // A note-on landing on a slot that is freed in the same cycle keeps it
  // active, so neither a set nor a clear is counted there.
  assign w_set = w_wr_on & ~r_active[w_wr_idx];
  assign w_clr = w_free_hit & r_active[w_free_idx] &
                 ~(w_wr_on & (w_wr_idx == w_free_idx));

  // -------------------------------------------------------------------------
  // Event latch and scan bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      r_ev_type    <= EV_ON;
      r_ev_ch      <= '0;
      r_ev_note    <= '0;
      r_ev_vel     <= '0;
      r_idx        <= '0;
      r_have_match <= 1'b0;
      r_have_free  <= 1'b0;
      r_match_idx  <= '0;
      r_free_idx   <= '0;
    end else if (w_accept) begin
      // Note-on with zero velocity is a note-off by MIDI convention.
      r_ev_type    <= ((bus.ev_type == EV_ON) && (bus.ev_data2 == 7'd0)) ? EV_OFF : bus.ev_type;
      r_ev_ch      <= bus.ev_channel;
      r_ev_note    <= bus.ev_data1;
      r_ev_vel     <= bus.ev_data2;
      r_idx        <= '0;
      r_have_match <= 1'b0;
      r_have_free  <= 1'b0;
    end else if ((r_state == ST_SCAN) && !w_scan_last) begin
      if (w_cur_match && !r_have_match) begin
        r_have_match <= 1'b1;
        r_match_idx  <= w_cur;
      end
      if (w_cur_free && !r_have_free) begin
        r_have_free <= 1'b1;
        r_free_idx  <= w_cur;
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Slot table. The issue write comes after the free so it wins on collision.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        r_active[i] <= 1'b0;
        r_held[i]   <= 1'b0;
        r_ch[i]     <= '0;
        r_nt[i]     <= '0;
      end
    end else begin
      if (w_free_hit) begin
        r_active[w_free_idx] <= 1'b0;
        r_held[w_free_idx]   <= 1'b0;
      end
      if (w_wr_on) begin
        r_active[w_wr_idx] <= 1'b1;
        r_held[w_wr_idx]   <= 1'b1;
        r_ch[w_wr_idx]     <= r_ev_ch;
        r_nt[w_wr_idx]     <= r_ev_note;
      end
      if (w_wr_off) begin
        r_held[w_wr_idx] <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Counters, handshake and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_steal    <= '0;
      r_ready    <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_keypress <= 1'b0;
      r_pitch    <= 1'b0;
      r_dropped  <= 1'b0;
      r_note     <= '0;
      r_vel      <= '0;
      r_chan     <= '0;
      r_addr     <= '0;
    end else begin
      r_count <= r_count + (ADDR_W + 1)'(w_set) - (ADDR_W + 1)'(w_clr);
      if (w_steal_adv) begin
        r_steal <= (r_steal == LAST) ? '0 : r_steal + 1'b1;
      end
      r_ready    <= (w_state_next == ST_IDLE);
      r_pressed  <= w_p_pressed;
      r_released <= w_p_released;
      r_keypress <= w_p_keypress;
      r_pitch    <= w_p_pitch;
      r_dropped  <= w_p_dropped;
      r_note     <= w_note_n;
      r_vel      <= w_vel_n;
      r_chan     <= w_chan_n;
      r_addr     <= w_addr_n;
    end
  end

  assign bus.ev_ready      = r_ready;
  assign bus.note_pressed  = r_pressed;
  assign bus.note_released = r_released;
  assign bus.note_keypress = r_keypress;
  assign bus.pitch_wheel   = r_pitch;
  assign bus.ev_dropped    = r_dropped;
  assign bus.note          = r_note;
  assign bus.velocity      = r_vel;
  assign bus.channel       = r_chan;
  assign bus.addr          = r_addr;
  assign bus.active_count  = r_count;
  assign bus.dbg_state     = r_state;
  assign bus.dbg_steal_ptr = r_steal;

endmodule
